// File: rtl/color_pkg.sv
// ---------------------------------------------------------------------------
// color_pkg
// Shared types for the colour-match scheduler: RGB/HSV widths, the scheduler
// FSM state encoding and the packed HSV triple stored in the reference bank.
// ---------------------------------------------------------------------------
package color_pkg;

   localparam int HSV_W = 9;
   localparam int RGB_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CONV  = 3'd1,
      STORE = 3'd2,
      CMP   = 3'd3,
      DONE  = 3'd4
   } sched_state_t;

   typedef struct packed {
      logic [HSV_W-1:0] h;
      logic [HSV_W-1:0] s;
      logic [HSV_W-1:0] v;
   } hsv_t;

endpackage

// File: rtl/color_match_sched_ref_bank.sv
// ---------------------------------------------------------------------------
// ref_bank
// NUM_REF x 27-bit register file holding the taught reference colours.
//   clk, rst       : clock, synchronous active-high clear of data and valids
//   we_i           : write strobe; stores wr_data_i and marks slot valid
//   wr_idx_i       : slot written
//   wr_data_i      : HSV value written
//   rd_idx_i       : slot read (combinational)
//   rd_data_o      : HSV value of slot rd_idx_i
//   valid_o        : per-slot "taught" bits
// ---------------------------------------------------------------------------
module ref_bank
   import color_pkg::*;
#(
   parameter int NUM_REF = 4,
   parameter int IDX_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we_i,
   input  logic [IDX_W-1:0]   wr_idx_i,
   input  hsv_t               wr_data_i,
   input  logic [IDX_W-1:0]   rd_idx_i,
   output hsv_t               rd_data_o,
   output logic [NUM_REF-1:0] valid_o
);

   hsv_t               bank_q [NUM_REF];
   logic [NUM_REF-1:0] valid_q;

   // NOTE: the bank is small and must read as zero after reset (cmp_ref_*
   // shows bank contents), so it is built from resettable flops rather than
   // a RAM macro; large arrays would normally be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REF; i++) begin
            bank_q[i] <= '0;
         end
         valid_q <= '0;
      end else if (we_i) begin
         bank_q[wr_idx_i]  <= wr_data_i;
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   assign rd_data_o = bank_q[rd_idx_i];
   assign valid_o   = valid_q;

endmodule

// File: rtl/color_match_sched.sv
// ---------------------------------------------------------------------------
// color_match_sched
// Time-multiplexes one rgb_hsv converter and one HSV comparator over a bank
// of taught reference colours. A sample is either taught into a slot or
// matched against every valid slot; the lowest matching slot is reported.
//   clk, rst                 : clock, synchronous active-high reset
//   s_valid / s_ready        : sample handshake (ready only when idle)
//   s_r, s_g, s_b            : sample RGB
//   s_teach, s_idx           : 1 = store into slot s_idx, 0 = match
//   conv_r/g/b               : shared converter inputs (hold last sample)
//   conv_h/s/v               : shared converter outputs
//   cmp_live_h/s/v           : comparator hsv1 (converted sample)
//   cmp_ref_h/s/v            : comparator hsv2 (reference slot)
//   cmp_similar              : comparator result
//   ref_valid                : per-slot taught bits
//   match_valid/hit/idx      : one-cycle result strobe, hit flag, lowest slot
//   teach_done               : one-cycle strobe when a slot write completes
// ---------------------------------------------------------------------------
module color_match_sched
   import color_pkg::*;
#(
   parameter int NUM_REF  = 4,
   parameter int IDX_W    = 2,
   parameter int CONV_LAT = 3,
   parameter int CMP_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [RGB_W-1:0]   s_r,
   input  logic [RGB_W-1:0]   s_g,
   input  logic [RGB_W-1:0]   s_b,
   input  logic               s_teach,
   input  logic [IDX_W-1:0]   s_idx,
   output logic [RGB_W-1:0]   conv_r,
   output logic [RGB_W-1:0]   conv_g,
   output logic [RGB_W-1:0]   conv_b,
   input  logic [HSV_W-1:0]   conv_h,
   input  logic [HSV_W-1:0]   conv_s,
   input  logic [HSV_W-1:0]   conv_v,
   output logic [HSV_W-1:0]   cmp_live_h,
   output logic [HSV_W-1:0]   cmp_live_s,
   output logic [HSV_W-1:0]   cmp_live_v,
   output logic [HSV_W-1:0]   cmp_ref_h,
   output logic [HSV_W-1:0]   cmp_ref_s,
   output logic [HSV_W-1:0]   cmp_ref_v,
   input  logic               cmp_similar,
   output logic [NUM_REF-1:0] ref_valid,
   output logic               match_valid,
   output logic               match_hit,
   output logic [IDX_W-1:0]   match_idx,
   output logic               teach_done
);

   localparam logic [3:0]       CONV_LOAD = 4'(CONV_LAT - 1);
   localparam logic [2:0]       CMP_LOAD  = 3'(CMP_LAT);
   localparam logic [IDX_W-1:0] LAST_PTR  = IDX_W'(NUM_REF - 1);

   sched_state_t     state_q,    state_d;
   logic [3:0]       conv_cnt_q, conv_cnt_d;
   logic [2:0]       cmp_cnt_q,  cmp_cnt_d;
   logic [IDX_W-1:0] ref_ptr_q,  ref_ptr_d;
   logic             teach_q,    teach_d;
   logic [IDX_W-1:0] idx_q,      idx_d;
   logic [RGB_W-1:0] rgb_r_q,    rgb_r_d;
   logic [RGB_W-1:0] rgb_g_q,    rgb_g_d;
   logic [RGB_W-1:0] rgb_b_q,    rgb_b_d;
   hsv_t             live_q,     live_d;
   hsv_t             ref_hold_q, ref_hold_d;
   logic             hit_q,      hit_d;
   logic [IDX_W-1:0] hit_idx_q,  hit_idx_d;

   logic             bank_we;
   hsv_t             bank_rd;
   logic             slot_valid;
   hsv_t             ref_out;

   ref_bank #(
      .NUM_REF (NUM_REF),
      .IDX_W   (IDX_W)
   ) u_ref_bank (
      .clk       (clk),
      .rst       (rst),
      .we_i      (bank_we),
      .wr_idx_i  (idx_q),
      .wr_data_i (live_q),
      .rd_idx_i  (ref_ptr_q),
      .rd_data_o (bank_rd),
      .valid_o   (ref_valid)
   );

   assign slot_valid = ref_valid[ref_ptr_q];

   // NOTE: every signal written here gets its default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      conv_cnt_d  = conv_cnt_q;
      cmp_cnt_d   = cmp_cnt_q;
      ref_ptr_d   = ref_ptr_q;
      teach_d     = teach_q;
      idx_d       = idx_q;
      rgb_r_d     = rgb_r_q;
      rgb_g_d     = rgb_g_q;
      rgb_b_d     = rgb_b_q;
      live_d      = live_q;
      ref_hold_d  = ref_hold_q;
      hit_d       = hit_q;
      hit_idx_d   = hit_idx_q;
      s_ready     = 1'b0;
      bank_we     = 1'b0;
      teach_done  = 1'b0;
      match_valid = 1'b0;

      unique case (state_q)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               rgb_r_d    = s_r;
               rgb_g_d    = s_g;
               rgb_b_d    = s_b;
               teach_d    = s_teach;
               idx_d      = s_idx;
               conv_cnt_d = CONV_LOAD;
               // Previous result stays visible until a new match begins.
               if (!s_teach) begin
                  hit_d     = 1'b0;
                  hit_idx_d = '0;
               end
               state_d = CONV;
            end
         end

         CONV: begin
            if (conv_cnt_q == 4'd0) begin
               live_d = '{h: conv_h, s: conv_s, v: conv_v};
               if (teach_q) begin
                  state_d = STORE;
               end else begin
                  ref_ptr_d = '0;
                  cmp_cnt_d = CMP_LOAD;
                  state_d   = CMP;
               end
            end else begin
               conv_cnt_d = conv_cnt_q - 4'd1;
            end
         end

         STORE: begin
            bank_we    = 1'b1;
            teach_done = 1'b1;
            state_d    = IDLE;
         end

         CMP: begin
            ref_hold_d = bank_rd;
            // Invalid slots cost one cycle; valid slots wait for the
            // comparator and are sampled on their last cycle.
            if (!slot_valid || cmp_cnt_q == 3'd0) begin
               if (slot_valid && cmp_similar && !hit_q) begin
                  hit_d     = 1'b1;
                  hit_idx_d = ref_ptr_q;
               end
               if (ref_ptr_q == LAST_PTR) begin
                  state_d = DONE;
               end else begin
                  ref_ptr_d = ref_ptr_q + IDX_W'(1);
                  cmp_cnt_d = CMP_LOAD;
               end
            end else begin
               cmp_cnt_d = cmp_cnt_q - 3'd1;
            end
         end

         DONE: begin
            match_valid = 1'b1;
            state_d     = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         conv_cnt_q <= '0;
         cmp_cnt_q  <= '0;
         ref_ptr_q  <= '0;
         teach_q    <= 1'b0;
         idx_q      <= '0;
         rgb_r_q    <= '0;
         rgb_g_q    <= '0;
         rgb_b_q    <= '0;
         live_q     <= '0;
         ref_hold_q <= '0;
         hit_q      <= 1'b0;
         hit_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         conv_cnt_q <= conv_cnt_d;
         cmp_cnt_q  <= cmp_cnt_d;
         ref_ptr_q  <= ref_ptr_d;
         teach_q    <= teach_d;
         idx_q      <= idx_d;
         rgb_r_q    <= rgb_r_d;
         rgb_g_q    <= rgb_g_d;
         rgb_b_q    <= rgb_b_d;
         live_q     <= live_d;
         ref_hold_q <= ref_hold_d;
         hit_q      <= hit_d;
         hit_idx_q  <= hit_idx_d;
      end
   end

   // The reference port follows the bank during CMP and otherwise holds the
   // last slot presented, so teaching does not disturb the comparator input.
   assign ref_out = (state_q == CMP) ? bank_rd : ref_hold_q;

   assign conv_r     = rgb_r_q;
   assign conv_g     = rgb_g_q;
   assign conv_b     = rgb_b_q;
   assign cmp_live_h = live_q.h;
   assign cmp_live_s = live_q.s;
   assign cmp_live_v = live_q.v;
   assign cmp_ref_h  = ref_out.h;
   assign cmp_ref_s  = ref_out.s;
   assign cmp_ref_v  = ref_out.v;
   assign match_hit  = hit_q;
   assign match_idx  = hit_idx_q;

endmodule

// File: tb/tb_color_match_sched.sv
// ---------------------------------------------------------------------------
// tb_color_match_sched
// Directed bench for color_match_sched with default parameters. The converter
// model passes RGB through as HSV after a CONV_LAT-cycle pipeline; the
// comparator model flags equality of live and reference HSV one cycle late,
// or can be forced to "similar" to probe which slots actually get sampled.
// ---------------------------------------------------------------------------
module tb_color_match_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [7:0] s_r = '0, s_g = '0, s_b = '0;
   logic       s_teach = 1'b0;
   logic [1:0] s_idx = '0;
   logic [7:0] conv_r, conv_g, conv_b;
   logic [8:0] conv_h, conv_s, conv_v;
   logic [8:0] cmp_live_h, cmp_live_s, cmp_live_v;
   logic [8:0] cmp_ref_h, cmp_ref_s, cmp_ref_v;
   logic       cmp_similar;
   logic [3:0] ref_valid;
   logic       match_valid, match_hit, teach_done;
   logic [1:0] match_idx;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   color_match_sched dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_r         (s_r),
      .s_g         (s_g),
      .s_b         (s_b),
      .s_teach     (s_teach),
      .s_idx       (s_idx),
      .conv_r      (conv_r),
      .conv_g      (conv_g),
      .conv_b      (conv_b),
      .conv_h      (conv_h),
      .conv_s      (conv_s),
      .conv_v      (conv_v),
      .cmp_live_h  (cmp_live_h),
      .cmp_live_s  (cmp_live_s),
      .cmp_live_v  (cmp_live_v),
      .cmp_ref_h   (cmp_ref_h),
      .cmp_ref_s   (cmp_ref_s),
      .cmp_ref_v   (cmp_ref_v),
      .cmp_similar (cmp_similar),
      .ref_valid   (ref_valid),
      .match_valid (match_valid),
      .match_hit   (match_hit),
      .match_idx   (match_idx),
      .teach_done  (teach_done)
   );

   // Converter model: two register stages so a value applied at the start of
   // cycle 1 is stable only from cycle 3 (CONV_LAT = 3).
   logic [26:0] conv_p1 = '0, conv_p2 = '0;
   always @(posedge clk) begin
      conv_p1 <= {1'b0, conv_r, 1'b0, conv_g, 1'b0, conv_b};
      conv_p2 <= conv_p1;
   end
   assign {conv_h, conv_s, conv_v} = conv_p2;

   // Comparator model: one cycle of latency (CMP_LAT = 1).
   logic sim_q = 1'b0;
   logic force_sim = 1'b0;
   always @(posedge clk) begin
      sim_q <= ({cmp_live_h, cmp_live_s, cmp_live_v} ==
                {cmp_ref_h, cmp_ref_s, cmp_ref_v});
   end
   assign cmp_similar = force_sim | sim_q;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Transfer happens on the posedge ending the negedge cycle used here
   // (cycle 0); s_valid is dropped right after.
   task automatic send(input bit teach, input logic [1:0] idx,
                       input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
      @(negedge clk);
      s_teach = teach;
      s_idx   = idx;
      s_r     = r;
      s_g     = g;
      s_b     = b;
      s_valid = 1'b1;
      check("ready_at_send", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   // Returns the cycle number of the first strobe (-1 on timeout) and
   // whether s_ready was seen high while busy.
   task automatic wait_strobe(input bit want_match, output int cyc,
                              output bit ready_seen);
      cyc        = -1;
      ready_seen = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (s_ready) ready_seen = 1'b1;
         if (want_match ? match_valid : teach_done) begin
            cyc = n;
            break;
         end
      end
   endtask

   int  cyc;
   bit  rdy;
   int  xfer_cnt, mv_cyc, second;
   bit  mv_seen;

   initial begin
      do_reset();

      // Reset state.
      @(negedge clk);
      check("rst_s_ready",     32'(s_ready),     32'd1);
      check("rst_ref_valid",   32'(ref_valid),   32'd0);
      check("rst_match_valid", 32'(match_valid), 32'd0);
      check("rst_teach_done",  32'(teach_done),  32'd0);
      check("rst_match_hit",   32'(match_hit),   32'd0);
      check("rst_match_idx",   32'(match_idx),   32'd0);
      check("rst_conv_rgb",    32'({conv_r, conv_g, conv_b}), 32'd0);
      check("rst_cmp_live",    32'({cmp_live_h, cmp_live_s, cmp_live_v}), 32'd0);
      check("rst_cmp_ref",     32'({cmp_ref_h, cmp_ref_s, cmp_ref_v}), 32'd0);

      // Empty bank: comparator forced similar, but no slot may be sampled.
      force_sim = 1'b1;
      send(1'b0, 2'd0, 8'h11, 8'h22, 8'h33);
      wait_strobe(1'b1, cyc, rdy);
      check("empty_latency", 32'(cyc), 32'd8);
      check("empty_hit",     32'(match_hit), 32'd0);
      check("empty_idx",     32'(match_idx), 32'd0);
      check("empty_ready",   32'(rdy), 32'd0);
      force_sim = 1'b0;

      // Teach slot 2.
      send(1'b1, 2'd2, 8'h1F, 8'h5E, 8'h6E);
      wait_strobe(1'b0, cyc, rdy);
      check("teach_latency",   32'(cyc), 32'd4);
      check("teach_ready_low", 32'(rdy), 32'd0);
      @(negedge clk);
      check("teach_ref_valid", 32'(ref_valid), 32'b0100);
      check("teach_done_1cyc", 32'(teach_done), 32'd0);
      check("teach_conv_hold", 32'({conv_r, conv_g, conv_b}), 32'h1F5E6E);
      check("teach_live",      32'({cmp_live_h, cmp_live_s, cmp_live_v}),
            32'({9'h01F, 9'h05E, 9'h06E}));

      // Sparse bank: reset erases slot 2, then only slot 3 is taught.
      do_reset();
      @(negedge clk);
      check("reset_erases", 32'(ref_valid), 32'd0);
      send(1'b1, 2'd3, 8'h40, 8'h50, 8'h60);
      wait_strobe(1'b0, cyc, rdy);
      force_sim = 1'b1;
      send(1'b0, 2'd0, 8'h01, 8'h02, 8'h03);
      wait_strobe(1'b1, cyc, rdy);
      check("sparse_latency", 32'(cyc), 32'd9);
      check("sparse_hit",     32'(match_hit), 32'd1);
      check("sparse_idx",     32'(match_idx), 32'd3);
      force_sim = 1'b0;

      // Full bank: slots 1 and 3 equal the live sample (slot 3 overwritten).
      send(1'b1, 2'd0, 8'd10, 8'h50, 8'h60);
      wait_strobe(1'b0, cyc, rdy);
      send(1'b1, 2'd1, 8'd20, 8'h50, 8'h60);
      wait_strobe(1'b0, cyc, rdy);
      send(1'b1, 2'd2, 8'd30, 8'h50, 8'h60);
      wait_strobe(1'b0, cyc, rdy);
      send(1'b1, 2'd3, 8'd20, 8'h50, 8'h60);
      wait_strobe(1'b0, cyc, rdy);
      check("full_ref_valid", 32'(ref_valid), 32'hF);
      send(1'b0, 2'd0, 8'd20, 8'h50, 8'h60);
      wait_strobe(1'b1, cyc, rdy);
      check("match_latency", 32'(cyc), 32'd12);
      check("match_hit",     32'(match_hit), 32'd1);
      check("match_idx_low", 32'(match_idx), 32'd1);
      check("match_ready",   32'(rdy), 32'd0);
      @(negedge clk);
      check("match_valid_1cyc", 32'(match_valid), 32'd0);
      check("result_hold",      32'({match_hit, match_idx}), 32'({1'b1, 2'd1}));
      check("cmp_ref_last",     32'(cmp_ref_h), 32'd20);

      // Teaching slot 3 must not disturb the held comparator reference.
      send(1'b1, 2'd3, 8'd40, 8'h50, 8'h60);
      wait_strobe(1'b0, cyc, rdy);
      @(negedge clk);
      check("cmp_ref_hold",   32'(cmp_ref_h), 32'd20);
      check("hit_across_teach", 32'({match_hit, match_idx}), 32'({1'b1, 2'd1}));

      // No hit with all slots valid: result cleared, latency unchanged.
      send(1'b0, 2'd0, 8'd99, 8'h50, 8'h60);
      wait_strobe(1'b1, cyc, rdy);
      check("nohit_latency", 32'(cyc), 32'd12);
      check("nohit_hit",     32'(match_hit), 32'd0);
      check("nohit_idx",     32'(match_idx), 32'd0);

      // Back-pressure: s_valid held high through a match against slot 2.
      @(negedge clk);
      s_teach  = 1'b0;
      s_idx    = 2'd0;
      s_r      = 8'd30;
      s_g      = 8'h50;
      s_b      = 8'h60;
      s_valid  = 1'b1;
      xfer_cnt = 0;
      mv_cyc   = -1;
      second   = -1;
      for (int c = 0; c <= 30; c++) begin
         if (c > 0) @(negedge clk);
         if (match_valid && mv_cyc < 0) mv_cyc = c;
         if (s_ready) begin
            xfer_cnt++;
            if (c > 0) begin
               second = c;
               break;
            end
         end
      end
      @(posedge clk);
      #1 s_valid = 1'b0;
      check("bp_match_cycle",  32'(mv_cyc), 32'd12);
      check("bp_next_xfer",    32'(second), 32'd13);
      check("bp_xfer_count",   32'(xfer_cnt), 32'd2);
      wait_strobe(1'b1, cyc, rdy);
      check("bp_second_lat",   32'(cyc), 32'd12);
      check("bp_second_idx",   32'({match_hit, match_idx}), 32'({1'b1, 2'd2}));

      // Reset during CMP (cycle 6): no strobe, bank erased, idle afterwards.
      send(1'b0, 2'd0, 8'd30, 8'h50, 8'h60);
      mv_seen = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (match_valid) mv_seen = 1'b1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_ref_valid", 32'(ref_valid), 32'd0);
      check("midrst_ready",     32'(s_ready), 32'd1);
      for (int n = 0; n < 15; n++) begin
         if (match_valid) mv_seen = 1'b1;
         @(negedge clk);
      end
      check("midrst_no_strobe", 32'(mv_seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
